// File: rtl/data_mem_mmio.sv
// CPU data memory with a 16-register memory-mapped IO window at IO_BASE.
// The IO window holds LEDs, synchronised switches, a prescaled timer with
// compare, and a sticky match flag that drives a level interrupt.
// Reads are registered. data_out is zero whenever rd_valid is low.
// IO_BASE is expected to be 16-aligned, because addr[3:0] selects the IO register.
module data_mem_mmio #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int IO_BASE = 'hF0,
  parameter int LED_W   = 16,
  parameter int SW_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_write,
  input  logic              mem_read,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  leds_out,
  output logic              irq
);

  localparam int WW     = 2 * DATA_W;
  localparam int RAM_AW = $clog2(IO_BASE);
  localparam int IO_END = IO_BASE + 16;

  logic [DATA_W-1:0] ram_q [0:IO_BASE-1];
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;
  logic [LED_W-1:0]  led_q, led_d;
  logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
  logic [DATA_W-1:0] timer_q, timer_d, pc_q, pc_d, presc_q, presc_d, cmp_q, cmp_d;
  logic              match_q, match_d, irq_en_q, irq_en_d;

  logic              ram_sel, io_sel, wr_io, tick, set_match;
  logic [3:0]        io_off;
  logic [DATA_W-1:0] rdata, timer_inc;
  logic [WW-1:0]     led_ext, sw_ext, led_wide;
  logic              wr_led_lo, wr_led_hi, wr_timer, wr_cmp, wr_status, wr_presc;

  // Address decode: RAM below IO_BASE, 16 IO registers from IO_BASE upwards.
  assign ram_sel = (32'(addr) < 32'(IO_BASE));
  assign io_sel  = (32'(addr) >= 32'(IO_BASE)) && (32'(addr) < 32'(IO_END));
  assign io_off  = addr[3:0];
  assign wr_io   = mem_write && io_sel;

  assign wr_led_lo = wr_io && (io_off == 4'd0);
  assign wr_led_hi = wr_io && (io_off == 4'd1);
  assign wr_timer  = wr_io && (io_off == 4'd4);
  assign wr_cmp    = wr_io && (io_off == 4'd5);
  assign wr_status = wr_io && (io_off == 4'd6);
  assign wr_presc  = wr_io && (io_off == 4'd7);

  // LEDs and switches are zero-extended to two bus words for LO/HI access.
  assign led_ext = WW'(led_q);
  assign sw_ext  = WW'(sw_s2_q);

  // Read mux, sampled into data_out_q at the clock edge. Sampling at the edge
  // gives read-before-write for free.
  always_comb begin
    rdata = '0;
    if (ram_sel) begin
      rdata = ram_q[addr[RAM_AW-1:0]];
    end else if (io_sel) begin
      case (io_off)
        4'd0:    rdata = led_ext[DATA_W-1:0];
        4'd1:    rdata = led_ext[WW-1:DATA_W];
        4'd2:    rdata = sw_ext[DATA_W-1:0];
        4'd3:    rdata = sw_ext[WW-1:DATA_W];
        4'd4:    rdata = timer_q;
        4'd5:    rdata = cmp_q;
        4'd6:    rdata = DATA_W'({irq_en_q, match_q});
        4'd7:    rdata = presc_q;
        default: rdata = '0;
      endcase
    end
  end

  // Next-state logic for the IO registers and the prescaled timer.
  always_comb begin
    led_wide = led_ext;
    if (wr_led_lo) led_wide[DATA_W-1:0]  = data_in;
    if (wr_led_hi) led_wide[WW-1:DATA_W] = data_in;
    led_d = led_wide[LED_W-1:0];

    tick      = (pc_q == presc_q);
    timer_inc = timer_q + 1'b1;

    pc_d = pc_q + 1'b1;
    if (tick || wr_timer || wr_presc) pc_d = '0;

    timer_d = timer_q;
    if (wr_timer)  timer_d = '0;
    else if (tick) timer_d = timer_inc;

    // A timer write cancels a coincident tick, so it cannot raise MATCH.
    set_match = tick && !wr_timer && (timer_inc == cmp_q);

    cmp_d    = wr_cmp ? data_in : cmp_q;
    presc_d  = wr_presc ? data_in : presc_q;
    irq_en_d = wr_status ? data_in[1] : irq_en_q;

    // W1C on MATCH. A set event in the same cycle takes priority over the clear.
    match_d = match_q;
    if (wr_status && data_in[0]) match_d = 1'b0;
    if (set_match)               match_d = 1'b1;
  end

  // RAM array: plain write port, no reset.
  always_ff @(posedge clk) begin
    if (mem_write && ram_sel) ram_q[addr[RAM_AW-1:0]] <= data_in;
  end

  // Registered state: read pipeline, IO registers, timer, switch synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      led_q      <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      timer_q    <= '0;
      pc_q       <= '0;
      presc_q    <= '0;
      cmp_q      <= '1;
      match_q    <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      data_out_q <= mem_read ? rdata : '0;
      rd_valid_q <= mem_read;
      led_q      <= led_d;
      sw_s1_q    <= sw_in;
      sw_s2_q    <= sw_s1_q;
      timer_q    <= timer_d;
      pc_q       <= pc_d;
      presc_q    <= presc_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      irq_en_q   <= irq_en_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign leds_out = led_q;
  assign irq      = match_q & irq_en_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio. The driver pushes the expected read data
// and the cycle at which it is due. A negedge monitor pops the queue and
// compares whenever rd_valid is high.
module tb_data_mem_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [7:0]  data_in;
  logic        mem_write;
  logic        mem_read;
  logic [7:0]  data_out;
  logic        rd_valid;
  logic [15:0] sw_in;
  logic [15:0] leds_out;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t_edge;

  logic [7:0] exp_q[$];
  int         cyc_q[$];

  data_mem_mmio dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .mem_write(mem_write), .mem_read(mem_read), .data_out(data_out),
    .rd_valid(rd_valid), .sw_in(sw_in), .leds_out(leds_out), .irq(irq)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks: inputs change on the falling edge and are sampled on the next rising edge
  task automatic bus(input logic [7:0] a, input logic [7:0] d, input logic we,
                     input logic re, input logic [7:0] e);
    @(negedge clk);
    addr = a; data_in = d; mem_write = we; mem_read = re;
    if (re) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc + 1);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus(a, d, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    bus(a, 8'h00, 1'b0, 1'b1, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mem_write = 1'b0; mem_read = 1'b0;
    end
  endtask

  // Monitor and scoreboard
  always @(negedge clk) begin
    logic [7:0] d;
    int c;
    if (cyc_q.size() > 0 && !rd_valid && cyc >= cyc_q[0]) begin
      vectors++; miscompares++;
      $display("FAIL read_missing: got rd_valid=0 expected rd_valid=1 (cycle %0d)", cyc);
      d = exp_q.pop_front();
      c = cyc_q.pop_front();
    end
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL read_unexpected: got rd_valid=1 data %0h expected rd_valid=0 (cycle %0d)",
                 data_out, cyc);
      end else begin
        d = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("read_data", data_out, d);
        check("read_latency", cyc, c);
      end
    end else if (data_out !== 8'h00) begin
      vectors++; miscompares++;
      $display("FAIL idle_data_out: got %0h expected 0 (cycle %0d)", data_out, cyc);
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    rst = 1'b1; addr = '0; data_in = '0; mem_write = 1'b0; mem_read = 1'b0; sw_in = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_leds", leds_out, 16'h0000);
    check("reset_irq", irq, 1'b0);
    check("reset_rd_valid", rd_valid, 1'b0);
    rst = 1'b0;

    // Reset values seen through the bus
    rd(8'hF5, 8'hFF);          // CMP
    rd(8'hF6, 8'h00);          // STATUS
    rd(8'hF0, 8'h00);          // LED_LO

    // RAM write, then read
    wr(8'h10, 8'h5A);
    rd(8'h10, 8'h5A);

    // Read and write to the same address in one cycle return the old value
    wr(8'h20, 8'h11);
    bus(8'h20, 8'h22, 1'b1, 1'b1, 8'h11);
    rd(8'h20, 8'h22);

    // LEDs
    wr(8'hF0, 8'hA5);
    wr(8'hF1, 8'h3C);
    idle(1);
    check("leds_set", leds_out, 16'h3CA5);
    wr(8'h7F, 8'hFF);
    idle(1);
    check("leds_after_ram_wr", leds_out, 16'h3CA5);
    rd(8'h7F, 8'hFF);
    rd(8'hF0, 8'hA5);
    rd(8'hF1, 8'h3C);

    // Unused IO offsets read 0 and ignore writes, including the top address
    wr(8'hF9, 8'h55);
    rd(8'hF9, 8'h00);
    wr(8'hFF, 8'hAA);
    rd(8'hFF, 8'h00);

    // Switches: two-cycle synchroniser latency
    rd(8'hF2, 8'h00);
    sw_in = 16'hBEEF;
    rd(8'hF3, 8'h00);
    rd(8'hF2, 8'hEF);
    rd(8'hF3, 8'hBE);
    wr(8'hF2, 8'h00);
    rd(8'hF2, 8'hEF);

    // Timer write clears it. With PRESC=0 it then ticks every cycle
    wr(8'hF4, 8'h77);
    rd(8'hF4, 8'h00);
    rd(8'hF4, 8'h01);

    // Timer compare: PRESC=3, CMP=2, IRQ_EN=1, then clear the timer
    wr(8'hF7, 8'h03);
    wr(8'hF5, 8'h02);
    wr(8'hF6, 8'h03);
    wr(8'hF4, 8'h00);
    t_edge = cyc + 1;
    idle(1);
    while (cyc < t_edge + 7) @(negedge clk);
    check("irq_before_match", irq, 1'b0);
    @(negedge clk);
    check("irq_at_match", irq, 1'b1);
    rd(8'hF6, 8'h03);
    rd(8'hF7, 8'h03);
    rd(8'hF5, 8'h02);
    wr(8'hF6, 8'h03);          // W1C MATCH, keep IRQ_EN
    idle(1);
    check("irq_after_w1c", irq, 1'b0);
    rd(8'hF6, 8'h02);
    idle(2);

    // Reset asserted alongside a read: the read is dropped
    @(negedge clk);
    addr = 8'h10; mem_read = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_read_valid", rd_valid, 1'b0);
    check("rst_leds", leds_out, 16'h0000);
    mem_read = 1'b0; rst = 1'b0;
    rd(8'hF5, 8'hFF);
    idle(3);
    check("queue_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
